// File: rtl/dac_pkg.sv
// Shared constants and types for the DAC frame scheduler and its packer.
package dac_pkg;

    localparam int SAMPLE_W = 12;
    localparam logic [SAMPLE_W-1:0] MIDSCALE = 12'h800;
    localparam int MIN_PERIOD = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DEFER
    } sched_state_t;

    typedef struct packed {
        logic [SAMPLE_W-1:0] left;
        logic [SAMPLE_W-1:0] right;
    } frame_t;

endpackage

// File: rtl/dac_frame_scheduler_if.sv
// Byte handshake between the host FIFO read port and the frame scheduler.
interface dac_frame_scheduler_if;

    logic       byte_valid;
    logic       byte_ready;
    logic [7:0] byte_data;

    modport master (
        output byte_valid,
        output byte_data,
        input  byte_ready
    );

    modport slave (
        input  byte_valid,
        input  byte_data,
        output byte_ready
    );

endinterface

// File: rtl/dac_frame_packer.sv
// Collects four FIFO bytes into one staged stereo frame until consumed.
module dac_frame_packer
    import dac_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   enable,
    input  logic   consume,
    dac_frame_scheduler_if.slave fifo,
    output frame_t frame,
    output logic   frame_pending
);

    logic [1:0] idx;
    logic [7:0] lo_l;
    logic [3:0] hi_l;
    logic [7:0] lo_r;
    logic       accept;

    assign fifo.byte_ready = enable && !frame_pending;
    assign accept = fifo.byte_valid && fifo.byte_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx           <= '0;
            lo_l          <= '0;
            hi_l          <= '0;
            lo_r          <= '0;
            frame         <= '0;
            frame_pending <= 1'b0;
        end else if (!enable) begin
            idx           <= '0;
            frame_pending <= 1'b0;
        end else begin
            if (consume)
                frame_pending <= 1'b0;
            if (accept) begin
                idx <= idx + 2'd1;
                unique case (idx)
                    2'd0: lo_l <= fifo.byte_data;
                    2'd1: hi_l <= fifo.byte_data[3:0];
                    2'd2: lo_r <= fifo.byte_data;
                    2'd3: begin
                        frame.left    <= {hi_l, lo_l};
                        frame.right   <= {fifo.byte_data[3:0], lo_r};
                        frame_pending <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/dac_frame_scheduler.sv
// Releases one stereo frame per sample period to the DAC, repeating on underrun.
// Optional DAC_SCHED_UNDERRUN_COUNT_EN adds a saturating underrun_count output.
module dac_frame_scheduler #(
    parameter int          PERIOD_W       = 16,
    parameter int unsigned DEFAULT_PERIOD = 283,
    parameter logic [11:0] MIDSCALE       = dac_pkg::MIDSCALE
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                period_wr,
    input  logic [PERIOD_W-1:0] period_data,
    dac_frame_scheduler_if.slave fifo,
    input  logic                dac_idle,
    output logic                dac_en,
    output logic [11:0]         dac_left,
    output logic [11:0]         dac_right,
    output logic                underrun,
    output logic                frame_pending
`ifdef DAC_SCHED_UNDERRUN_COUNT_EN
    ,
    output logic [15:0]         underrun_count
`endif
);

    localparam logic [PERIOD_W-1:0] P_RST = PERIOD_W'(DEFAULT_PERIOD);
    localparam logic [PERIOD_W-1:0] P_MIN = PERIOD_W'(dac_pkg::MIN_PERIOD);
    localparam logic [PERIOD_W-1:0] ONE   = PERIOD_W'(1);

    dac_pkg::sched_state_t state;
    dac_pkg::sched_state_t state_next;
    dac_pkg::frame_t       frame;

    logic [PERIOD_W-1:0] count;
    logic [PERIOD_W-1:0] period;
    logic [PERIOD_W-1:0] period_next;
    logic                tick;
    logic                issue;
    logic                drop;
    logic                consume;

    dac_frame_packer u_packer (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .consume       (consume),
        .fifo          (fifo),
        .frame         (frame),
        .frame_pending (frame_pending)
    );

    assign tick = (state != dac_pkg::IDLE) && (count == period - ONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= dac_pkg::IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        drop       = 1'b0;
        if (!enable) begin
            state_next = dac_pkg::IDLE;
        end else begin
            unique case (state)
                dac_pkg::IDLE: state_next = dac_pkg::RUN;
                dac_pkg::RUN: begin
                    if (tick) begin
                        if (dac_idle)
                            issue = 1'b1;
                        else
                            state_next = dac_pkg::DEFER;
                    end
                end
                dac_pkg::DEFER: begin
                    // a fresh tick while one is still owed is lost
                    drop = tick;
                    if (dac_idle) begin
                        issue      = 1'b1;
                        state_next = dac_pkg::RUN;
                    end
                end
                default: state_next = dac_pkg::IDLE;
            endcase
        end
        consume = issue && frame_pending;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count       <= '0;
            period      <= P_RST;
            period_next <= P_RST;
            dac_en      <= 1'b0;
            underrun    <= 1'b0;
            dac_left    <= MIDSCALE;
            dac_right   <= MIDSCALE;
        end else begin
            dac_en   <= issue;
            underrun <= drop || (issue && !frame_pending);
            if (consume) begin
                dac_left  <= frame.left;
                dac_right <= frame.right;
            end
            if (period_wr)
                period_next <= (period_data < P_MIN) ? P_MIN : period_data;
            if (!enable || state == dac_pkg::IDLE || tick)
                count <= '0;
            else
                count <= count + ONE;
            // idle restart counts as a wrap for a pending period change
            if (state == dac_pkg::IDLE || tick)
                period <= period_next;
        end
    end

`ifdef DAC_SCHED_UNDERRUN_COUNT_EN
    logic enable_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            enable_q       <= 1'b0;
            underrun_count <= '0;
        end else begin
            enable_q <= enable;
            if (enable && !enable_q)
                underrun_count <= '0;
            else if (underrun && underrun_count != 16'hFFFF)
                underrun_count <= underrun_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dac_frame_scheduler.sv
// Scoreboard bench for dac_frame_scheduler: expected DAC pulses are queued
// with their cycle stamp as stimulus is driven and checked as they appear.
module tb_dac_frame_scheduler;
    import dac_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        period_wr;
    logic [15:0] period_data;
    logic        dac_idle;
    logic        dac_en;
    logic [11:0] dac_left;
    logic [11:0] dac_right;
    logic        underrun;
    logic        frame_pending;
`ifdef DAC_SCHED_UNDERRUN_COUNT_EN
    logic [15:0] underrun_count;
`endif

    always #5 clk = ~clk;

    dac_frame_scheduler_if fifo ();

    dac_frame_scheduler dut (
        .clk           (clk),
        .reset         (rst_n),
        .enable        (enable),
        .period_wr     (period_wr),
        .period_data   (period_data),
        .fifo          (fifo),
        .dac_idle      (dac_idle),
        .dac_en        (dac_en),
        .dac_left      (dac_left),
        .dac_right     (dac_right),
        .underrun      (underrun),
        .frame_pending (frame_pending)
`ifdef DAC_SCHED_UNDERRUN_COUNT_EN
        ,
        .underrun_count(underrun_count)
`endif
    );

    typedef struct {
        int          at;
        logic        en;
        logic [11:0] l;
        logic [11:0] r;
        logic        unr;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [7:0]  src[$];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic        take = 1'b0;
    logic [11:0] last_l = MIDSCALE;
    logic [11:0] last_r = MIDSCALE;
    int          c;
    int          c2;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model: a byte leaves the queue when it was taken at the edge
    always @(negedge clk) take <= fifo.byte_valid && fifo.byte_ready;

    always @(posedge clk) begin
        #1;
        if (take && src.size() > 0)
            void'(src.pop_front());
        fifo.byte_valid = (src.size() > 0);
        if (src.size() > 0)
            fifo.byte_data = src[0];
        else
            fifo.byte_data = 8'h00;
    end

    always @(negedge clk) begin
        if (rst_n && (dac_en || underrun)) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse", 32'(cyc), 32'(0));
            end else begin
                mon_e = sb.pop_front();
                chk("pulse_at", 32'(cyc), 32'(mon_e.at));
                chk("dac_en", 32'(dac_en), 32'(mon_e.en));
                chk("dac_left", 32'(dac_left), 32'(mon_e.l));
                chk("dac_right", 32'(dac_right), 32'(mon_e.r));
                chk("underrun", 32'(underrun), 32'(mon_e.unr));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) step();
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while (sb.size() > 0 && n < limit) begin
            step();
            n++;
        end
        chk("drain", 32'(sb.size()), 32'(0));
    endtask

    task automatic push_frame(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3);
        src.push_back(b0);
        src.push_back(b1);
        src.push_back(b2);
        src.push_back(b3);
    endtask

    task automatic expect_frame(input int at, input logic [11:0] l,
                                input logic [11:0] r);
        sb.push_back('{at: at, en: 1'b1, l: l, r: r, unr: 1'b0});
        last_l = l;
        last_r = r;
    endtask

    task automatic expect_under(input int at, input logic en);
        sb.push_back('{at: at, en: en, l: last_l, r: last_r, unr: 1'b1});
    endtask

    initial begin
        rst_n            = 1'b0;
        enable           = 1'b0;
        period_wr        = 1'b0;
        period_data      = '0;
        dac_idle         = 1'b1;
        fifo.byte_valid  = 1'b0;
        fifo.byte_data   = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(fifo.byte_ready), 32'(0));
        chk("rst_dac_en", 32'(dac_en), 32'(0));
        chk("rst_underrun", 32'(underrun), 32'(0));
        chk("rst_pending", 32'(frame_pending), 32'(0));
        chk("rst_left", 32'(dac_left), 32'h800);
        chk("rst_right", 32'(dac_right), 32'h800);
        step();
        rst_n = 1'b1;
        step();

        // starved start, then three frames, then starvation repeats the last
        c = cyc;
        enable = 1'b1;
        expect_under(c + 284, 1'b1);
        wait_to(c + 290);
        push_frame(8'h34, 8'h12, 8'h78, 8'h56);
        push_frame(8'hAB, 8'hFC, 8'h01, 8'hF2);
        push_frame(8'h00, 8'h0F, 8'hFF, 8'h30);
        expect_frame(c + 284 + 283, 12'h234, 12'h678);
        expect_frame(c + 284 + 566, 12'hCAB, 12'h201);
        expect_frame(c + 284 + 849, 12'hF00, 12'h0FF);
        expect_under(c + 284 + 1132, 1'b1);
        wait_to(c + 300);
        chk("pending_set", 32'(frame_pending), 32'(1));
        chk("ready_low", 32'(fifo.byte_ready), 32'(0));
        drain(1500);
        enable = 1'b0;
        step();
        step();

        // DAC busy across a tick defers the release without drift
        c = cyc;
        enable = 1'b1;
        push_frame(8'h34, 8'h12, 8'h78, 8'h56);
        push_frame(8'hAB, 8'hFC, 8'h01, 8'hF2);
        expect_frame(c + 290, 12'h234, 12'h678);
        expect_frame(c + 567, 12'hCAB, 12'h201);
        wait_to(c + 279);
        dac_idle = 1'b0;
        wait_to(c + 289);
        dac_idle = 1'b1;
        drain(600);
        enable = 1'b0;
        step();
        step();

        // partial frame is flushed when enable drops
        c = cyc;
        enable = 1'b1;
        src.push_back(8'hAB);
        src.push_back(8'hCD);
        wait_to(c + 10);
        chk("partial_pending", 32'(frame_pending), 32'(0));
        enable = 1'b0;
        step();
        step();
        chk("held_left", 32'(dac_left), 32'(last_l));
        chk("held_right", 32'(dac_right), 32'(last_r));
        chk("idle_ready", 32'(fifo.byte_ready), 32'(0));
        repeat (5) step();
        c2 = cyc;
        enable = 1'b1;
        push_frame(8'h00, 8'h0F, 8'hFF, 8'h30);
        expect_frame(c2 + 284, 12'hF00, 12'h0FF);
        drain(600);
        enable = 1'b0;
        step();
        step();

        // period changes land on the following wrap; 2 clamps to 4
        c = cyc;
        enable = 1'b1;
        expect_under(c + 284, 1'b1);
        expect_under(c + 384, 1'b1);
        expect_under(c + 484, 1'b1);
        expect_under(c + 488, 1'b1);
        expect_under(c + 492, 1'b1);
        wait_to(c + 100);
        period_wr = 1'b1;
        period_data = 16'd100;
        step();
        period_wr = 1'b0;
        wait_to(c + 400);
        period_wr = 1'b1;
        period_data = 16'd2;
        step();
        period_wr = 1'b0;
        wait_to(c + 492);
        dac_idle = 1'b0;
        expect_under(c + 500, 1'b0);
        expect_under(c + 502, 1'b1);
        expect_under(c + 504, 1'b1);
        wait_to(c + 501);
        dac_idle = 1'b1;
        drain(600);
        enable = 1'b0;
        step();
        step();

`ifdef DAC_SCHED_UNDERRUN_COUNT_EN
        c = cyc;
        enable = 1'b1;
        expect_under(c + 5, 1'b1);
        expect_under(c + 9, 1'b1);
        expect_under(c + 13, 1'b1);
        wait_to(c + 14);
        chk("underrun_count", 32'(underrun_count), 32'(3));
        enable = 1'b0;
        step();
        step();
        enable = 1'b1;
        step();
        step();
        chk("count_cleared", 32'(underrun_count), 32'(0));
        enable = 1'b0;
        step();
        step();
`endif

        // asynchronous reset in the middle of a frame
        c = cyc;
        enable = 1'b1;
        src.push_back(8'h11);
        src.push_back(8'h22);
        src.push_back(8'h33);
        wait_to(c + 4);
        #1;
        rst_n = 1'b0;
        enable = 1'b0;
        #1;
        chk("arst_left", 32'(dac_left), 32'h800);
        chk("arst_right", 32'(dac_right), 32'h800);
        chk("arst_pending", 32'(frame_pending), 32'(0));
        chk("arst_ready", 32'(fifo.byte_ready), 32'(0));
        chk("arst_dac_en", 32'(dac_en), 32'(0));
        chk("sb_empty", 32'(sb.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dac_frame_scheduler.md
# dac_frame_scheduler

Sample-rate scheduler between the host byte FIFO read port and `dac_interface`. Assembles 4-byte stereo frames, releases exactly one frame per programmable sample period, and defers a release while the DAC shift is still busy. On underrun it repeats the last sample, so the DAC output rate never stalls. Runs entirely in the core (SPI) clock domain.

## Interface
- `PERIOD_W`, 16: width of the sample-period counter and register.
- `DEFAULT_PERIOD`, 283: period in `clk` cycles loaded at reset.
- `MIDSCALE`, 12'h800: sample value output before the first real frame.
- `clk`  in  1  core clock; the block has one clock.
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  run/stop; low flushes partial frames and stops the counter.
- `period_wr`  in  1  one-cycle strobe that loads `period_data`.
- `period_data`  in  PERIOD_W  new sample period, in `clk` cycles.
- `byte_valid`  in  1  FIFO read data valid.
- `byte_ready`  out  1  scheduler accepts a byte this cycle.
- `byte_data`  in  8  FIFO read data.
- `dac_idle`  in  1  `dac_interface` can accept `dac_en`.
- `dac_en`  out  1  one-cycle load strobe to `dac_interface`.
- `dac_left`  out  12  left sample; held stable between strobes.
- `dac_right`  out  12  right sample; held stable between strobes.
- `underrun`  out  1  one-cycle pulse when a tick found no complete frame.
- `frame_pending`  out  1  a complete frame is staged.

## Operation
- Transfer rule: a byte moves when `byte_valid && byte_ready` in the same cycle (standard valid/ready).
- `byte_ready = enable && !frame_pending`. It is combinational from registered state only.
- Byte order within a frame: L[7:0], L[11:8] taken from `byte_data[3:0]`, R[7:0], R[11:8] taken from `byte_data[3:0]`. Upper nibbles are ignored.
- The 2-bit byte index wraps 3→0. On the 4th byte, the staging register loads and `frame_pending` sets.
- Period counter: counts 0..P-1. A tick occurs on the cycle the count equals P-1; the counter wraps to 0 on that cycle.
- `period_wr`: the new value is captured immediately, but takes effect only at the next wrap. Values below 4 are clamped to 4.
- States:
  - IDLE: `enable` low.
  - RUN: counting.
  - DEFER: a tick is owed while the DAC is busy.
- IDLE → RUN on `enable` high. The counter starts at 0, so the first tick comes P cycles later.
- RUN, tick with `frame_pending && dac_idle`: the staged frame moves to the outputs, `dac_en` pulses, and `frame_pending` clears.
- RUN, tick with `!frame_pending`: `underrun` pulses, `dac_en` pulses, and the outputs keep their previous values.
- RUN, tick with `!dac_idle`: go to DEFER. The counter keeps running (no drift accumulates).
- DEFER: on the first cycle with `dac_idle`, issue exactly as in RUN (including the underrun decision at that time), then return to RUN.
- If a second tick occurs while still in DEFER, it is dropped and `underrun` pulses.
- A frame completing on the tick cycle itself is not eligible for that tick. It waits for the next tick, and the tick counts as an underrun.
- Any state → IDLE when `enable` goes low:
  - byte index cleared, `frame_pending` cleared, counter cleared;
  - `dac_left`/`dac_right` held;
  - any pending DEFER is cancelled.

## Timing
- Reset values: `byte_ready`=0, `dac_en`=0, `underrun`=0, `frame_pending`=0, `dac_left`=`dac_right`=`MIDSCALE`, period=`DEFAULT_PERIOD`, state IDLE.
- `dac_en`, `dac_left`, `dac_right` and `underrun` are registered. They update in the cycle after the tick (or after the DEFER release). Samples change in the same cycle that `dac_en` is high.
- `frame_pending` is high from the cycle after the 4th byte is accepted. `byte_ready` falls in that same cycle.
- Sustained throughput is one frame per P cycles. P ≥ 4 guarantees a full frame can be accepted within a period.
- Asserting `reset` mid-frame immediately returns all registers to their reset values.

## Configuration
- `DAC_SCHED_UNDERRUN_COUNT_EN`
  - Defined: adds output `underrun_count` [15:0]. It increments on each `underrun` pulse, saturates at 16'hFFFF, and clears on reset or on the rising edge of `enable`.
  - Undefined: the port and counter are absent; the `underrun` pulse is unchanged.

## Structure
- Shared package `dac_pkg`:
  - sample width 12;
  - `MIDSCALE`;
  - minimum period 4;
  - scheduler state enum {IDLE, RUN, DEFER};
  - stereo frame struct {left, right}.
- One sub-module, `dac_frame_packer`. It contains the byte index, the staging register, `frame_pending`, and the consume input.
- The period counter and FSM stay in the top module.

## Test plan
- Reset, `enable`=1, P=283, bytes 34,12,78,56 supplied continuously → `dac_en` pulses every 283 cycles with L=12'h234, R=12'h678; no `underrun`.
- No bytes after `enable` → first `dac_en` 284 cycles after `enable` with L=R=12'h800 and `underrun`=1 on that pulse.
- `dac_idle` low for 10 cycles spanning a tick → `dac_en` in the cycle after `dac_idle` rises; the next tick still falls 283 cycles after the original tick.
- `period_wr` with 100 mid-period → the current period completes at 283, the following periods are 100; writing 2 yields period 4.
- `enable` dropped after 2 bytes, then re-raised with a fresh frame → the first frame output is the fresh one (no leftover bytes); outputs held during IDLE.
- With `DAC_SCHED_UNDERRUN_COUNT_EN`: 3 starved ticks → `underrun_count`=3; toggling `enable` → 0.
